// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: register address type, data width and register-file constants.
package rv32i_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after index `last`.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      int unsigned idx;
      idx = (int'(last) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back scheduler with registered RF write stage and busy scoreboard.
// Optional write-stage bypass to decode is enabled by defining WB_BYPASS_EN.
module regfile_wb_scheduler
  import rv32i_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = rv32i_pkg::XLEN
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  input  regaddr_t [NREQ-1:0]       req_rd_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_data_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic                      issue_valid_i,
  input  regaddr_t                  issue_rd_i,
  input  regaddr_t                  rs1_i,
  input  regaddr_t                  rs2_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o,
  output logic                      rf_wr_en_o,
  output regaddr_t                  rf_addr_o,
  output logic [XLEN-1:0]           rf_data_o,
  output logic                      fwd1_valid_o,
  output logic                      fwd2_valid_o,
  output logic [XLEN-1:0]           fwd1_data_o,
  output logic [XLEN-1:0]           fwd2_data_o
);

  localparam int unsigned LW = $clog2(NREQ);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  logic [LW-1:0]       last_q;
  logic [NREQ-1:0]     grant;
  logic [LW-1:0]       gidx;
  logic                any_grant;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid_i),
    .last  (last_q),
    .grant (grant)
  );

  // Gating with reset keeps ready low while the block is held in reset.
  assign req_ready_o = grant & {NREQ{rst_ni}};
  assign any_grant   = |grant;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = LW'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= LAST_RST;
    end else if (any_grant) begin
      last_q <= gidx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wr_en_o <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
    end else if (any_grant) begin
      rf_wr_en_o <= (req_rd_i[gidx] != REG_ZERO);
      rf_addr_o  <= req_rd_i[gidx];
      rf_data_o  <= req_data_i[gidx];
    end else begin
      rf_wr_en_o <= 1'b0;
    end
  end

  // Set is applied after clear so a new producer of the same rd keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_wr_en_o) busy_d[rf_addr_o] = 1'b0;
    if (issue_valid_i && issue_rd_i != REG_ZERO) busy_d[issue_rd_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_valid_o = rf_wr_en_o && (rf_addr_o == rs1_i) && (rs1_i != REG_ZERO);
  assign fwd2_valid_o = rf_wr_en_o && (rf_addr_o == rs2_i) && (rs2_i != REG_ZERO);
  assign fwd1_data_o  = rf_data_o;
  assign fwd2_data_o  = rf_data_o;
  assign rs1_busy_o   = busy_q[rs1_i] & ~fwd1_valid_o;
  assign rs2_busy_o   = busy_q[rs2_i] & ~fwd2_valid_o;
`else
  assign fwd1_valid_o = 1'b0;
  assign fwd2_valid_o = 1'b0;
  assign fwd1_data_o  = '0;
  assign fwd2_data_o  = '0;
  assign rs1_busy_o   = busy_q[rs1_i];
  assign rs2_busy_o   = busy_q[rs2_i];
`endif

endmodule
